// File: rtl/salesman_pkg.sv
// Shared types and fixed-point constants for the annealer's Metropolis stage.
package salesman_pkg;

  // Fixed-point widths: x is signed .17, y is signed .23, recip is unsigned .15
  localparam int X_W     = 21;
  localparam int Y_W     = 27;
  localparam int RECIP_W = 17;
  localparam int Y_FRAC  = 23;

  localparam int NTERM_DEF = 15;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    WAIT,
    JUDGE
  } state_t;

  // Reciprocal coefficients floor(2^15 / (NTERM-k)) for the default term count
  localparam logic [RECIP_W-1:0] RECIP [NTERM_DEF] = '{
    17'd2184,  17'd2340,  17'd2520,  17'd2730,  17'd2978,
    17'd3276,  17'd3640,  17'd4096,  17'd4681,  17'd5461,
    17'd6553,  17'd8192,  17'd10922, 17'd16384, 17'd32768
  };

  // Same coefficient for an arbitrary term count; used to build elaboration-time tables
  function automatic logic [RECIP_W-1:0] recip_coef(input int k, input int nterm);
    return RECIP_W'((1 << 15) / (nterm - k));
  endfunction

endpackage

// File: rtl/metropolis_judge_xorshift32.sv
// xorshift32 uniform generator; advances one step per cycle while step is high.
module xorshift32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] out
);

  logic [31:0] x_q;
  logic [31:0] x_d;
  logic [31:0] t1;
  logic [31:0] t2;

  // Next state: x ^= x<<13; x ^= x>>17; x ^= x<<5
  always_comb begin
    t1  = x_q ^ (x_q << 13);
    t2  = t1 ^ (t1 >> 17);
    x_d = t2 ^ (t2 << 5);
  end

  // State register; reset reloads the seed so a reset always restarts the sequence
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= seed;
    end else if (step) begin
      x_q <= x_d;
    end
  end

  assign out = x_q;

endmodule

// File: rtl/metropolis_judge.sv
// Metropolis accept/reject stage: fast-accepts non-positive deltas, otherwise
// sequences the exp unit through init/run and judges its result against a
// xorshift32 uniform.
module metropolis_judge
  import salesman_pkg::*;
#(
  parameter logic [31:0] SEED    = 32'h2545F491,
  parameter int          NTERM   = 15,
  parameter int          EXP_LAT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [X_W-1:0]     delta,
  output logic                      busy,
  output logic                      valid,
  output logic                      accept,
  output logic signed [X_W-1:0]     exp_x,
  output logic                      exp_init,
  output logic                      exp_run,
  output logic [RECIP_W-1:0]        exp_recip,
  input  logic signed [Y_W-1:0]     exp_y
);

  localparam int K_W = (NTERM > 1) ? $clog2(NTERM) : 1;
  localparam int W_W = (EXP_LAT > 1) ? $clog2(EXP_LAT) : 1;

  state_t                 state_q;
  logic [K_W-1:0]         k_q;
  logic [W_W-1:0]         wait_q;
  logic                   valid_q;
  logic                   accept_q;
  logic signed [X_W-1:0]  exp_x_q;
  logic                   exp_init_q;
  logic                   exp_run_q;
  logic [RECIP_W-1:0]     recip_q;

  logic [31:0]            rng;
  logic                   rng_step;
  logic [Y_W-1:0]         u_ext;
  logic                   win;
  logic                   fast_path;
  logic                   unused_rng_hi;

  // Coefficient table resolved at elaboration time, one entry per series term
  logic [RECIP_W-1:0] recip_tab [NTERM];

  genvar gi;
  generate
    for (gi = 0; gi < NTERM; gi++) begin : g_recip
      assign recip_tab[gi] = recip_coef(gi, NTERM);
    end
  endgenerate

  // The rng advances exactly once per slow-path verdict
  assign rng_step = (state_q == JUDGE);

  xorshift32 u_rng (
    .clk   (clk),
    .reset (reset),
    .step  (rng_step),
    .seed  (SEED),
    .out   (rng)
  );

  // u = 0.rng[22:0] in .23; a negative exp_y never wins, saturated values always do
  assign u_ext         = {{(Y_W-Y_FRAC){1'b0}}, rng[Y_FRAC-1:0]};
  assign win           = ~exp_y[Y_W-1] && ($unsigned(exp_y) > u_ext);
  assign unused_rng_hi = ^rng[31:Y_FRAC];

  assign fast_path = delta[X_W-1] || (delta == '0);

  // Sequencer with registered outputs. Because the exp-side outputs trail the
  // state by one cycle, WAIT spans EXP_LAT state cycles so that JUDGE samples
  // exp_y exactly EXP_LAT cycles after the last visible exp_run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      wait_q     <= '0;
      valid_q    <= 1'b0;
      accept_q   <= 1'b0;
      exp_x_q    <= '0;
      exp_init_q <= 1'b0;
      exp_run_q  <= 1'b0;
      recip_q    <= '0;
    end else begin
      valid_q    <= 1'b0;
      accept_q   <= 1'b0;
      exp_init_q <= 1'b0;
      exp_run_q  <= 1'b0;
      recip_q    <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (fast_path) begin
              valid_q  <= 1'b1;
              accept_q <= 1'b1;
            end else begin
              exp_x_q <= delta;
              state_q <= INIT;
            end
          end
        end
        INIT: begin
          exp_init_q <= 1'b1;
          k_q        <= '0;
          state_q    <= RUN;
        end
        RUN: begin
          exp_run_q <= 1'b1;
          recip_q   <= recip_tab[k_q];
          if (k_q == K_W'(NTERM - 1)) begin
            k_q     <= '0;
            wait_q  <= '0;
            state_q <= WAIT;
          end else begin
            k_q <= k_q + K_W'(1);
          end
        end
        WAIT: begin
          if (wait_q == W_W'(EXP_LAT - 1)) begin
            state_q <= JUDGE;
          end else begin
            wait_q <= wait_q + W_W'(1);
          end
        end
        JUDGE: begin
          valid_q  <= 1'b1;
          accept_q <= win;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign valid     = valid_q;
  assign accept    = accept_q;
  assign exp_x     = exp_x_q;
  assign exp_init  = exp_init_q;
  assign exp_run   = exp_run_q;
  assign exp_recip = recip_q;

endmodule
